// File: rtl/rhythm_pkg.sv
// Shared encodings for the rhythm game: FSM states and accuracy grades.
// Also consumed by the accuracy HEX decoder and the VGA note drawer.
package rhythm_pkg;

   localparam int unsigned ST_W  = 2;
   localparam int unsigned ACC_W = 2;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE    = 2'b00,
      ST_PLAYING = 2'b01,
      ST_DONE    = 2'b10
   } state_e;

   // Codes increase with severity, so the worst grade is the largest code.
   typedef enum logic [ACC_W-1:0] {
      ACC_NONE    = 2'b00,
      ACC_PERFECT = 2'b01,
      ACC_GOOD    = 2'b10,
      ACC_MISS    = 2'b11
   } acc_e;

endpackage

// File: rtl/rhythm_lane.sv
// One lane: note shift map, button press edge detect, hit window search
// and per-lane hit/perfect/miss flags for the current cycle.
module rhythm_lane
   import rhythm_pkg::*;
#(
   parameter int unsigned DEPTH  = 192,
   parameter int unsigned GOOD_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_clear,
   input  logic             i_play,
   input  logic             i_tick,
   input  logic [DEPTH-1:0] i_load_map,
   input  logic             i_button_n,
   output logic [DEPTH-1:0] o_map,
   output logic             o_hit_c,
   output logic             o_perfect_c,
   output logic             o_miss_c
);

   localparam int unsigned WIN = 2 * GOOD_W + 1;

   logic             r_btn_d;
   logic             r_press;
   logic [DEPTH-1:0] r_map;
   logic [DEPTH-1:0] w_hit_mask;
   logic [DEPTH-1:0] w_after_hit;
   logic [DEPTH-1:0] w_map_nx;
   logic             w_found;
   logic             w_on_perfect;

   // Lowest occupied slot inside the hit window.
   always_comb begin
      w_found      = 1'b0;
      w_on_perfect = 1'b0;
      w_hit_mask   = '0;
      for (int unsigned i = 0; i < WIN; i++) begin
         if (!w_found && r_map[i]) begin
            w_found       = 1'b1;
            w_hit_mask[i] = 1'b1;
            w_on_perfect  = (i == GOOD_W);
         end
      end
   end

   // Grade against the pre-shift map; a note hit at index 0 cannot also miss.
   always_comb begin
      o_hit_c     = i_play & r_press & w_found;
      o_perfect_c = o_hit_c & w_on_perfect;
      w_after_hit = o_hit_c ? (r_map & ~w_hit_mask) : r_map;
      o_miss_c    = i_play & i_tick & w_after_hit[0];
      w_map_nx    = r_map;
      if (i_load) begin
         w_map_nx = i_load_map;
      end else if (i_clear) begin
         w_map_nx = '0;
      end else if (i_play) begin
         w_map_nx = i_tick ? (w_after_hit >> 1) : w_after_hit;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_btn_d <= 1'b1;
         r_press <= 1'b0;
         r_map   <= '0;
      end else begin
         r_btn_d <= i_button_n;
         r_press <= r_btn_d & ~i_button_n;
         r_map   <= w_map_nx;
      end
   end

   assign o_map = r_map;

endmodule

// File: rtl/rhythm_judge.sv
// Multi-lane rhythm judge: song FSM, saturating score/combo, worst-grade
// reduction and per-lane visible note window for the display logic.
module rhythm_judge
   import rhythm_pkg::*;
#(
   parameter int unsigned LANES       = 4,
   parameter int unsigned DEPTH       = 192,
   parameter int unsigned GOOD_W      = 1,
   parameter int unsigned VIEW        = 10,
   parameter int unsigned SCORE_W     = 8,
   parameter int unsigned COMBO_W     = 8,
   parameter int unsigned PERFECT_PTS = 2,
   parameter int unsigned GOOD_PTS    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     tick,
   input  logic [LANES*DEPTH-1:0]   load_map,
   input  logic [LANES-1:0]         button_n,
   output logic [ST_W-1:0]          state,
   output logic [LANES*VIEW-1:0]    view,
   output logic [SCORE_W-1:0]       score,
   output logic [COMBO_W-1:0]       combo,
   output logic [COMBO_W-1:0]       max_combo,
   output logic [ACC_W-1:0]         accuracy,
   output logic                     acc_valid,
   output logic [LANES-1:0]         hit_lanes
);

   localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);
   localparam logic [31:0] COMBO_MAX = 32'((64'd1 << COMBO_W) - 64'd1);

   state_e               r_state, w_state_nx;
   acc_e                 r_acc, w_acc_nx;
   logic                 r_start_d;
   logic [SCORE_W-1:0]   r_score, w_score_nx, w_score_sat;
   logic [COMBO_W-1:0]   r_combo, w_combo_nx, w_combo_sat;
   logic [COMBO_W-1:0]   r_max_combo, w_max_nx;
   logic                 r_acc_valid, w_acc_valid_nx;
   logic [LANES-1:0]     r_hit_lanes, w_hit_lanes_nx;

   logic                 w_playing, w_start_rise, w_load, w_clear, w_grade_en;
   logic [LANES*DEPTH-1:0] w_maps;
   logic [LANES-1:0]     w_hit, w_perfect, w_miss;
   logic [31:0]          w_pts, w_nhits, w_score_sum, w_combo_sum;

   assign w_playing    = (r_state == ST_PLAYING);
   assign w_start_rise = start & ~r_start_d;
   assign w_load       = w_start_rise & ~w_playing;
   assign w_clear      = w_playing & abort;
   assign w_grade_en   = w_playing & ~abort;

   for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
      rhythm_lane #(
         .DEPTH  (DEPTH),
         .GOOD_W (GOOD_W)
      ) u_lane (
         .clk         (clk),
         .rst         (rst),
         .i_load      (w_load),
         .i_clear     (w_clear),
         .i_play      (w_grade_en),
         .i_tick      (tick),
         .i_load_map  (load_map[gl*DEPTH +: DEPTH]),
         .i_button_n  (button_n[gl]),
         .o_map       (w_maps[gl*DEPTH +: DEPTH]),
         .o_hit_c     (w_hit[gl]),
         .o_perfect_c (w_perfect[gl]),
         .o_miss_c    (w_miss[gl])
      );
      assign view[gl*VIEW +: VIEW] = w_maps[gl*DEPTH + 1 +: VIEW];
   end

   // Points and hit count of this cycle, then saturating accumulation.
   always_comb begin
      w_pts   = '0;
      w_nhits = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         if (w_perfect[l]) begin
            w_pts = w_pts + 32'(PERFECT_PTS);
         end else if (w_hit[l]) begin
            w_pts = w_pts + 32'(GOOD_PTS);
         end
         w_nhits = w_nhits + 32'(w_hit[l]);
      end
      w_score_sum = 32'(r_score) + w_pts;
      w_combo_sum = 32'(r_combo) + w_nhits;
      w_score_sat = (w_score_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(w_score_sum);
      w_combo_sat = (w_combo_sum > COMBO_MAX) ? COMBO_W'(COMBO_MAX) : COMBO_W'(w_combo_sum);
   end

   always_comb begin
      w_state_nx     = r_state;
      w_score_nx     = r_score;
      w_combo_nx     = r_combo;
      w_max_nx       = r_max_combo;
      w_acc_nx       = r_acc;
      w_acc_valid_nx = 1'b0;
      w_hit_lanes_nx = '0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_start_rise) begin
               w_state_nx = ST_PLAYING;
               w_score_nx = '0;
               w_combo_nx = '0;
               w_max_nx   = '0;
               w_acc_nx   = ACC_NONE;
            end
         end
         ST_PLAYING: begin
            if (abort) begin
               w_state_nx = ST_IDLE;
               w_combo_nx = '0;
            end else begin
               if (w_maps == '0) begin
                  w_state_nx = ST_DONE;
               end
               w_hit_lanes_nx = w_hit;
               w_score_nx     = w_score_sat;
               if (|w_hit || |w_miss) begin
                  w_acc_valid_nx = 1'b1;
                  if (|w_miss) begin
                     w_acc_nx = ACC_MISS;
                  end else if (|(w_hit & ~w_perfect)) begin
                     w_acc_nx = ACC_GOOD;
                  end else begin
                     w_acc_nx = ACC_PERFECT;
                  end
                  // A miss anywhere breaks the combo even if other lanes hit.
                  w_combo_nx = (|w_miss) ? '0 : w_combo_sat;
                  w_max_nx   = (w_combo_nx > r_max_combo) ? w_combo_nx : r_max_combo;
               end
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_start_d   <= 1'b0;
         r_score     <= '0;
         r_combo     <= '0;
         r_max_combo <= '0;
         r_acc       <= ACC_NONE;
         r_acc_valid <= 1'b0;
         r_hit_lanes <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_start_d   <= start;
         r_score     <= w_score_nx;
         r_combo     <= w_combo_nx;
         r_max_combo <= w_max_nx;
         r_acc       <= w_acc_nx;
         r_acc_valid <= w_acc_valid_nx;
         r_hit_lanes <= w_hit_lanes_nx;
      end
   end

   assign state     = r_state;
   assign score     = r_score;
   assign combo     = r_combo;
   assign max_combo = r_max_combo;
   assign accuracy  = r_acc;
   assign acc_valid = r_acc_valid;
   assign hit_lanes = r_hit_lanes;

endmodule

// File: tb/tb_rhythm_judge.sv
// Bench for rhythm_judge: directed song scenarios plus random play, every
// cycle compared against a behavioural model of the game rules.
module tb_rhythm_judge;

   localparam int unsigned LANES = 4;
   localparam int unsigned DEPTH = 192;
   localparam int unsigned GOOD_W = 1;
   localparam int unsigned VIEW = 10;
   localparam int unsigned SCORE_W = 8;
   localparam int unsigned COMBO_W = 8;
   localparam int unsigned PERFECT_PTS = 2;
   localparam int unsigned GOOD_PTS = 1;
   localparam int SCORE_SAT = (1 << SCORE_W) - 1;
   localparam int COMBO_SAT = (1 << COMBO_W) - 1;

   logic                   clk;
   logic                   rst;
   logic                   start;
   logic                   abort;
   logic                   tick;
   logic [LANES*DEPTH-1:0] load_map;
   logic [LANES-1:0]       button_n;
   logic [1:0]             state;
   logic [LANES*VIEW-1:0]  view;
   logic [SCORE_W-1:0]     score;
   logic [COMBO_W-1:0]     combo;
   logic [COMBO_W-1:0]     max_combo;
   logic [1:0]             accuracy;
   logic                   acc_valid;
   logic [LANES-1:0]       hit_lanes;

   rhythm_judge #(
      .LANES(LANES), .DEPTH(DEPTH), .GOOD_W(GOOD_W), .VIEW(VIEW),
      .SCORE_W(SCORE_W), .COMBO_W(COMBO_W),
      .PERFECT_PTS(PERFECT_PTS), .GOOD_PTS(GOOD_PTS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .tick(tick),
      .load_map(load_map), .button_n(button_n), .state(state), .view(view),
      .score(score), .combo(combo), .max_combo(max_combo),
      .accuracy(accuracy), .acc_valid(acc_valid), .hit_lanes(hit_lanes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model state (value after the most recent clock edge).
   logic [DEPTH-1:0] m_map [LANES];
   int               m_state, m_score, m_combo, m_max, m_acc;
   bit               m_valid;
   logic [LANES-1:0] m_hits, m_press, m_btn_prev;
   bit               m_start_prev;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] model_view();
      logic [63:0] v;
      v = '0;
      for (int l = 0; l < LANES; l++)
         for (int k = 0; k < VIEW; k++)
            v[l*VIEW + k] = m_map[l][k+1];
      return v;
   endfunction

   // Game rules applied for one clock edge, using the inputs present at it.
   task automatic model_step();
      logic [LANES-1:0] new_press;
      int  pts, nh, worst, g;
      bit  miss, all_zero, found;
      new_press = m_btn_prev & ~button_n;
      if (!rst) begin
         m_state = 0; m_score = 0; m_combo = 0; m_max = 0; m_acc = 0;
         m_valid = 0; m_hits = '0; m_press = '0; m_btn_prev = '1; m_start_prev = 0;
         for (int l = 0; l < LANES; l++) m_map[l] = '0;
         return;
      end
      m_valid = 0;
      m_hits  = '0;
      if (m_state != 1 && start && !m_start_prev) begin
         m_state = 1; m_score = 0; m_combo = 0; m_max = 0; m_acc = 0;
         for (int l = 0; l < LANES; l++) m_map[l] = load_map[l*DEPTH +: DEPTH];
      end else if (m_state == 1 && abort) begin
         m_state = 0; m_combo = 0;
         for (int l = 0; l < LANES; l++) m_map[l] = '0;
      end else if (m_state == 1) begin
         all_zero = 1;
         for (int l = 0; l < LANES; l++) if (m_map[l] != '0) all_zero = 0;
         pts = 0; nh = 0; worst = 0; miss = 0;
         for (int l = 0; l < LANES; l++) begin
            if (m_press[l]) begin
               found = 0;
               for (int i = 0; i <= 2*GOOD_W; i++) begin
                  if (!found && m_map[l][i]) begin
                     found = 1;
                     g = (i == GOOD_W) ? 1 : 2;
                     pts += (g == 1) ? PERFECT_PTS : GOOD_PTS;
                     nh++;
                     if (g > worst) worst = g;
                     m_map[l][i] = 1'b0;
                     m_hits[l] = 1'b1;
                  end
               end
            end
            if (tick) begin
               if (m_map[l][0]) miss = 1;
               m_map[l] = m_map[l] >> 1;
            end
         end
         m_score = (m_score + pts > SCORE_SAT) ? SCORE_SAT : m_score + pts;
         if (nh > 0 || miss) begin
            m_valid = 1;
            m_acc   = miss ? 3 : worst;
            m_combo = miss ? 0 : ((m_combo + nh > COMBO_SAT) ? COMBO_SAT : m_combo + nh);
            if (m_combo > m_max) m_max = m_combo;
         end
         if (all_zero) m_state = 2;
      end
      m_press      = new_press;
      m_btn_prev   = button_n;
      m_start_prev = start;
   endtask

   task automatic compare_all();
      check("state",     64'(state),     64'(m_state));
      check("score",     64'(score),     64'(m_score));
      check("combo",     64'(combo),     64'(m_combo));
      check("max_combo", 64'(max_combo), 64'(m_max));
      check("accuracy",  64'(accuracy),  64'(m_acc));
      check("acc_valid", 64'(acc_valid), 64'(m_valid));
      check("hit_lanes", 64'(hit_lanes), 64'(m_hits));
      check("view",      64'(view),      model_view());
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         compare_all();
      end
   endtask

   task automatic restart_song();
      start = 1'b0;
      step(1);
      start = 1'b1;
      step(1);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0; tick = 1'b0;
      load_map = '0; button_n = '1;
      step(2);
      check("rst_state", 64'(state), 64'd0);
      check("rst_view",  64'(view),  64'd0);
      rst = 1'b1;
      step(1);

      // Single perfect on lane 0, then song drains to DONE.
      load_map = '0; load_map[1] = 1'b1;
      start = 1'b1;
      step(1);
      check("a_playing", 64'(state), 64'd1);
      button_n[0] = 1'b0;
      step(1);
      check("a_latency", 64'(score), 64'd0);
      step(1);
      check("a_acc",   64'(accuracy),  64'd1);
      check("a_score", 64'(score),     64'd2);
      check("a_combo", 64'(combo),     64'd1);
      check("a_valid", 64'(acc_valid), 64'd1);
      step(1);
      check("a_pulse", 64'(acc_valid), 64'd0);
      check("a_done",  64'(state),     64'd2);
      button_n = '1;

      // Miss on tick, then a press on an empty window.
      load_map = '0; load_map[0] = 1'b1; load_map[DEPTH+5] = 1'b1;
      restart_song();
      check("b_restart", 64'(score), 64'd0);
      tick = 1'b1; step(1); tick = 1'b0;
      check("b_acc",   64'(accuracy),  64'd3);
      check("b_combo", 64'(combo),     64'd0);
      check("b_valid", 64'(acc_valid), 64'd1);
      button_n[0] = 1'b0;
      step(2);
      check("b_empty_press", 64'(acc_valid), 64'd0);
      button_n = '1;
      step(1);
      abort = 1'b1; step(1); abort = 1'b0;
      check("b_abort", 64'(state), 64'd0);

      // Two lanes graded together, then again with a miss on a third lane.
      load_map = '0;
      load_map[0*DEPTH +: 3] = 3'b110;
      load_map[1*DEPTH +: 3] = 3'b001;
      load_map[2*DEPTH +: 3] = 3'b011;
      load_map[3*DEPTH + 50] = 1'b1;
      restart_song();
      button_n = 4'b1010;
      step(2);
      check("c1_score", 64'(score),    64'd3);
      check("c1_combo", 64'(combo),    64'd2);
      check("c1_acc",   64'(accuracy), 64'd2);
      button_n = '1; step(1);
      button_n = 4'b1010; step(1);
      tick = 1'b1; step(1); tick = 1'b0;
      check("c2_score", 64'(score),     64'd6);
      check("c2_combo", 64'(combo),     64'd0);
      check("c2_acc",   64'(accuracy),  64'd3);
      check("c2_max",   64'(max_combo), 64'd2);
      button_n = '1; step(1);
      abort = 1'b1; step(1); abort = 1'b0;

      // Press and tick together with the note at index 0.
      load_map = '0; load_map[0] = 1'b1; load_map[3*DEPTH + 60] = 1'b1;
      restart_song();
      button_n = 4'b1110; step(1);
      tick = 1'b1; step(1); tick = 1'b0;
      check("d_acc",   64'(accuracy), 64'd2);
      check("d_combo", 64'(combo),    64'd1);
      check("d_score", 64'(score),    64'd1);
      button_n = '1; step(1);
      abort = 1'b1; step(1); abort = 1'b0;
      check("e_state", 64'(state),     64'd0);
      check("e_view",  64'(view),      64'd0);
      check("e_max",   64'(max_combo), 64'd1);
      check("e_score", 64'(score),     64'd1);

      // Reset in the middle of a song.
      load_map = '0; load_map[3] = 1'b1; load_map[DEPTH+4] = 1'b1;
      restart_song();
      rst = 1'b0; step(1); rst = 1'b1;
      check("f_state", 64'(state), 64'd0);
      check("f_score", 64'(score), 64'd0);
      check("f_view",  64'(view),  64'd0);

      // Dense song: score must saturate and the song must drain to DONE.
      load_map = '1;
      restart_song();
      for (int c = 0; c < 650; c++) begin
         button_n = LANES'($urandom);
         tick = (c % 3 == 2);
         step(1);
      end
      button_n = '1; tick = 1'b0;
      step(1);
      check("g_done",      64'(state), 64'd2);
      check("g_score_sat", 64'(score), 64'd255);
      restart_song();
      check("g_restart_state", 64'(state), 64'd1);
      check("g_restart_score", 64'(score), 64'd0);

      // Random play with occasional restart, abort and reset.
      load_map = '0;
      for (int c = 0; c < 3000; c++) begin
         button_n = LANES'($urandom);
         tick  = ($urandom_range(0, 3) == 0);
         abort = ($urandom_range(0, 149) == 0);
         rst   = ($urandom_range(0, 499) != 0);
         if ($urandom_range(0, 39) == 0) start = ~start;
         for (int l = 0; l < LANES; l++)
            load_map[l*DEPTH +: 64] = {$urandom, $urandom};
         step(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
